// File: rtl/sample_mix_scheduler.sv
// Polls NUM_VOICES sample sources once per frame, sums them and hands the mix to the codec.
// Define MIX_SATURATE_EN to clamp the 21-bit sum to 18 bits; otherwise the sum wraps.
module sample_mix_scheduler #(
    parameter int NUM_VOICES = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  generate_next_sample,
    output logic [NUM_VOICES-1:0] voice_req,
    input  logic signed [17:0]    voice_sample,
    input  logic                  voice_valid,
    input  logic                  mute,
    input  logic                  clear_flags,
    output logic signed [17:0]    new_sample_out,
    output logic                  latch_new_sample,
    output logic                  busy,
    output logic                  timeout_flag,
    output logic                  overrun_flag
);
    localparam int IDX_W  = $clog2(NUM_VOICES);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, POLL, LATCH} state_t;

    state_t              state;
    logic [IDX_W-1:0]    index;
    logic [WAIT_W-1:0]   wait_cnt;
    logic signed [20:0]  acc;
    logic signed [17:0]  held_sample;
    logic signed [17:0]  mixed;
    logic                take;
    logic                skip;
    logic                advance;

    function automatic logic signed [17:0] convert(input logic signed [20:0] sum);
`ifdef MIX_SATURATE_EN
        if (sum > 21'sd131071)
            return 18'sd131071;
        if (sum < -21'sd131072)
            return 18'sh20000;
        return sum[17:0];
`else
        return sum[17:0];
`endif
    endfunction

    // A voice is skipped on the cycle after TIMEOUT silent cycles, so it occupies TIMEOUT+1 cycles.
    assign take    = (state == POLL) && voice_valid;
    assign skip    = (state == POLL) && !voice_valid && (wait_cnt == WAIT_MAX);
    assign advance = take || skip;
    assign busy    = (state != IDLE);

    // mute is looked at in the LATCH cycle itself, so the output is muxed live during LATCH.
    assign mixed          = mute ? 18'sd0 : convert(acc);
    assign new_sample_out = (state == LATCH) ? mixed : held_sample;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            index            <= '0;
            wait_cnt         <= '0;
            acc              <= '0;
            held_sample      <= '0;
            voice_req        <= '0;
            latch_new_sample <= 1'b0;
            timeout_flag     <= 1'b0;
            overrun_flag     <= 1'b0;
        end else begin
            latch_new_sample <= 1'b0;
            timeout_flag     <= skip | (timeout_flag & ~clear_flags);
            overrun_flag     <= (generate_next_sample && state != IDLE) |
                                (overrun_flag & ~clear_flags);
            case (state)
                IDLE: begin
                    if (generate_next_sample) begin
                        acc       <= '0;
                        index     <= '0;
                        wait_cnt  <= '0;
                        voice_req <= NUM_VOICES'(1);
                        state     <= POLL;
                    end
                end
                POLL: begin
                    if (advance) begin
                        wait_cnt <= '0;
                        if (take)
                            acc <= acc + $signed({{3{voice_sample[17]}}, voice_sample});
                        if (index == LAST_IDX) begin
                            voice_req        <= '0;
                            latch_new_sample <= 1'b1;
                            state            <= LATCH;
                        end else begin
                            index     <= index + IDX_W'(1);
                            voice_req <= voice_req << 1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                LATCH: begin
                    held_sample <= mixed;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_mix_scheduler.sv
// Bench for sample_mix_scheduler: frame-level model (voice time slots and sums) checked every cycle,
// plus directed literal checks for the documented scenarios.
module tb_sample_mix_scheduler;
    localparam int NV = 3;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, generate_next_sample, voice_valid, mute, clear_flags;
    logic [NV-1:0]      voice_req;
    logic signed [17:0] voice_sample, new_sample_out;
    logic               latch_new_sample, busy, timeout_flag, overrun_flag;

    sample_mix_scheduler #(.NUM_VOICES(NV), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .generate_next_sample(generate_next_sample),
        .voice_req(voice_req), .voice_sample(voice_sample), .voice_valid(voice_valid),
        .mute(mute), .clear_flags(clear_flags), .new_sample_out(new_sample_out),
        .latch_new_sample(latch_new_sample), .busy(busy),
        .timeout_flag(timeout_flag), .overrun_flag(overrun_flag)
    );

    int total = 0, bad = 0, cyc = 0, lat_cnt = 0;
    int dly[NV];     // cycles of request before a voice answers; negative means never
    int samp[NV];
    bit chk_en = 0;

    // frame model: each voice owns a time slot, the frame latches right after the last slot
    bit fr_act = 0;
    int f_t = 0, f_l = 0, f_sum = 0;
    int fs[NV], fd[NV];
    bit fto[NV];
    int e_out = 0;
    bit e_to = 0, e_ov = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (latch_new_sample) lat_cnt <= lat_cnt + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int conv(input int s);
        int m;
`ifdef MIX_SATURATE_EN
        if (s > 131071) return 131071;
        if (s < -131072) return -131072;
        return s;
`else
        m = s % 262144;
        if (m < 0) m += 262144;
        if (m >= 131072) m -= 262144;
        return m;
`endif
    endfunction

    task automatic start_frame(input int t);
        int s;
        bit ok;
        s = t + 1;
        f_sum = 0;
        for (int i = 0; i < NV; i++) begin
            ok = (dly[i] >= 0) && (dly[i] <= TO);
            fs[i] = s;
            fd[i] = ok ? dly[i] + 1 : TO + 1;
            fto[i] = !ok;
            if (ok) f_sum += samp[i];
            s += fd[i];
        end
        f_t = t;
        f_l = s;
        fr_act = 1;
    endtask

    always @(negedge clk) begin : model
        int er;
        bit el, eb, to_set, ov_set;
        if (chk_en) begin
            er = 0;
            to_set = 0;
            for (int i = 0; i < NV; i++)
                if (fr_act && cyc >= fs[i] && cyc < fs[i] + fd[i]) begin
                    er = er | (1 << i);
                    if (fto[i] && cyc == fs[i] + fd[i] - 1) to_set = 1;
                end
            el = fr_act && (cyc == f_l);
            eb = fr_act && (cyc > f_t) && (cyc <= f_l);
            if (el) e_out = mute ? 0 : conv(f_sum);
            chk("m_voice_req", int'(voice_req), er);
            chk("m_latch", int'(latch_new_sample), int'(el));
            chk("m_busy", int'(busy), int'(eb));
            chk("m_out", int'(new_sample_out), e_out);
            chk("m_timeout_flag", int'(timeout_flag), int'(e_to));
            chk("m_overrun_flag", int'(overrun_flag), int'(e_ov));
            ov_set = generate_next_sample && eb;
            if (reset) begin
                fr_act = 0; e_to = 0; e_ov = 0; e_out = 0;
            end else begin
                e_to = to_set | (e_to & !clear_flags);
                e_ov = ov_set | (e_ov & !clear_flags);
                if (el) fr_act = 0;
                if (generate_next_sample && !eb) start_frame(cyc);
            end
        end
    end

    // voice responder: answers after dly[v] request cycles, noise on the bus otherwise
    initial begin : responder
        logic [NV-1:0] prev;
        int seen, v;
        prev = '0; seen = 0; voice_valid = 1'b0; voice_sample = '0;
        forever begin
            @(posedge clk); #1;
            if (voice_req != '0) begin
                v = 0;
                for (int i = 0; i < NV; i++) if (voice_req[i]) v = i;
                seen = (voice_req == prev) ? seen + 1 : 0;
                voice_valid  = (dly[v] >= 0) && (seen >= dly[v]);
                voice_sample = voice_valid ? 18'(samp[v]) : 18'($urandom);
            end else begin
                seen = 0;
                voice_valid  = 1'($urandom_range(0, 1));
                voice_sample = 18'($urandom);
            end
            prev = voice_req;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
        @(negedge clk);
    endtask

    task automatic pulse_gen(output int t);
        step();
        generate_next_sample = 1'b1;
        t = cyc;
        step();
        generate_next_sample = 1'b0;
    endtask

    task automatic set_voices(input int s0, s1, s2, d0, d1, d2);
        samp[0] = s0; samp[1] = s1; samp[2] = s2;
        dly[0] = d0; dly[1] = d1; dly[2] = d2;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t, l0, n, r;
        reset = 1'b1; generate_next_sample = 1'b0; mute = 1'b0; clear_flags = 1'b0;
        set_voices(0, 0, 0, 0, 0, 0);
        repeat (3) step();
        chk_en = 1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_voice_req", int'(voice_req), 0);
        chk("rst_out", int'(new_sample_out), 0);
        chk("rst_latch", int'(latch_new_sample), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_flags", int'({timeout_flag, overrun_flag}), 0);

        // basic mix
        set_voices(100, -40, 7, 0, 0, 0);
        pulse_gen(t);
        @(negedge clk); chk("basic_req_v0", int'(voice_req), 1);
        goto(t + 2);    chk("basic_req_v1", int'(voice_req), 2);
        goto(t + 3);    chk("basic_req_v2", int'(voice_req), 4);
        goto(t + 4);    chk("basic_latch", int'(latch_new_sample), 1);
        chk("basic_out", int'(new_sample_out), 67);
        goto(t + 5);    chk("basic_busy_low", int'(busy), 0);
        chk("basic_hold", int'(new_sample_out), 67);

        // conversion of an out-of-range sum
        set_voices(100000, 100000, 100000, 0, 0, 0);
        pulse_gen(t);
        goto(t + 4);
        chk("sat_latch", int'(latch_new_sample), 1);
`ifdef MIX_SATURATE_EN
        chk("sat_out", int'(new_sample_out), 131071);
`else
        chk("wrap_out", int'(new_sample_out), 37856);
`endif
        goto(t + 5);

        // overrun and mute
        set_voices(1000, 2000, 3000, 0, 0, 0);
        l0 = lat_cnt;
        pulse_gen(t);
        step(); generate_next_sample = 1'b1;
        step(); generate_next_sample = 1'b0;
        step(); mute = 1'b1;
        @(negedge clk);
        chk("ovr_flag", int'(overrun_flag), 1);
        chk("mute_latch", int'(latch_new_sample), 1);
        chk("mute_out", int'(new_sample_out), 0);
        step(); mute = 1'b0;
        goto(t + 10);
        chk("ovr_single_latch", lat_cnt - l0, 1);
        step(); clear_flags = 1'b1;
        step(); clear_flags = 1'b0;
        @(negedge clk); chk("ovr_cleared", int'(overrun_flag), 0);

        // timeout on voice 1
        set_voices(5, 0, 9, 0, -1, 0);
        pulse_gen(t);
        goto(t + 11);
        chk("to_flag_set", int'(timeout_flag), 1);
        chk("to_no_early_latch", int'(latch_new_sample), 0);
        goto(t + 12);
        chk("to_latch", int'(latch_new_sample), 1);
        chk("to_out", int'(new_sample_out), 14);
        step(); clear_flags = 1'b1;
        @(negedge clk); chk("to_flag_before_clear", int'(timeout_flag), 1);
        step(); clear_flags = 1'b0;
        @(negedge clk); chk("to_flag_cleared", int'(timeout_flag), 0);

        // reset mid-frame, with a generate pulse coincident with reset
        set_voices(11, 22, 33, 1, 1, 1);
        l0 = lat_cnt;
        pulse_gen(t);
        step(); reset = 1'b1; generate_next_sample = 1'b1;
        step(); reset = 1'b0; generate_next_sample = 1'b0;
        @(negedge clk);
        chk("rmf_req", int'(voice_req), 0);
        chk("rmf_out", int'(new_sample_out), 0);
        chk("rmf_busy", int'(busy), 0);
        goto(t + 10);
        chk("rmf_no_latch", lat_cnt - l0, 0);
        pulse_gen(t);
        @(negedge clk); chk("rmf_restart_v0", int'(voice_req), 1);
        goto(t + 8);
        chk("rmf_restart_out", int'(new_sample_out), 66);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            n = 0;
            while (fr_act && n < 300) begin step(); n++; end
            for (int i = 0; i < NV; i++) begin
                r = $urandom_range(0, 9);
                dly[i] = (r < 6) ? int'($urandom_range(0, 2)) : (r < 8) ? -1 : (r == 8) ? TO : TO - 1;
                samp[i] = int'($urandom_range(0, 262143)) - 131072;
            end
            step();
            generate_next_sample = 1'b1;
            n = 0;
            while ((fr_act || n < 2) && n < 300) begin
                step();
                generate_next_sample = ($urandom_range(0, 15) == 0);
                mute        = ($urandom_range(0, 3) == 0);
                clear_flags = ($urandom_range(0, 7) == 0);
                reset       = ($urandom_range(0, 99) == 0);
                n++;
            end
            step();
            generate_next_sample = 1'b0; mute = 1'b0; clear_flags = 1'b0; reset = 1'b0;
            n = 0;
            while (fr_act && n < 300) begin step(); n++; end
            chk("rnd_frame_done", int'(fr_act), 0);
        end

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
